// File: rtl/divider32_seq_if.sv
// Start/busy/done handshake between the ALU sequencer and divider32_seq.
// The is_signed signal exists only when DIVIDER_SIGNED_EN is defined.
interface divider32_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
`ifdef DIVIDER_SIGNED_EN
    logic             is_signed;

    modport master (
        output start, dividend, divisor, is_signed,
        input  busy, done, quotient, remainder, div_by_zero
    );
    modport slave (
        input  start, dividend, divisor, is_signed,
        output busy, done, quotient, remainder, div_by_zero
    );
`else
    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );
    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
`endif
endinterface

// File: rtl/divider32_seq.sv
// Sequential restoring divider, one quotient bit per clock (WIDTH cycles per divide).
// Define DIVIDER_SIGNED_EN to add the is_signed operand mode.
module divider32_seq #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           reset,
    divider32_seq_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   q_reg;
    logic [WIDTH-1:0]   r_reg;
    logic [WIDTH-1:0]   d_reg;
    logic [CNT_W-1:0]   cnt;
    logic               neg_q;
    logic               neg_r;
    logic               busy_r;
    logic               done_r;
    logic               dbz_r;
    logic [WIDTH-1:0]   quot_r;
    logic [WIDTH-1:0]   rem_r;

    logic               accept;
    logic               div_zero;
    logic               last;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   r_shift;
    logic               s_bit;
    logic [WIDTH:0]     sub_sum;
    logic               take;
    logic [WIDTH-1:0]   r_next;
    logic [WIDTH-1:0]   q_next;
    logic [WIDTH-1:0]   q_final;
    logic [WIDTH-1:0]   r_final;

    assign accept   = (state == IDLE) && bus.start;
    assign div_zero = (bus.divisor == '0);
    assign last     = (cnt == CNT_W'(WIDTH - 1));

`ifdef DIVIDER_SIGNED_EN
    assign a_neg = bus.is_signed & bus.dividend[WIDTH-1];
    assign b_neg = bus.is_signed & bus.divisor[WIDTH-1];
`else
    assign a_neg = 1'b0;
    assign b_neg = 1'b0;
`endif
    // Magnitude of -2^(WIDTH-1) is itself when read unsigned, so no extra bit is needed.
    assign a_mag = a_neg ? -bus.dividend : bus.dividend;
    assign b_mag = b_neg ? -bus.divisor  : bus.divisor;

    // One restoring step: subtract via inverted divisor plus carry-in; carry out means no borrow.
    assign r_shift = {r_reg[WIDTH-2:0], q_reg[WIDTH-1]};
    assign s_bit   = r_reg[WIDTH-1];
    assign sub_sum = {1'b0, r_shift} + {1'b0, ~d_reg} + (WIDTH+1)'(1);
    assign take    = s_bit | sub_sum[WIDTH];
    assign r_next  = take ? sub_sum[WIDTH-1:0] : r_shift;
    assign q_next  = {q_reg[WIDTH-2:0], take};
    assign q_final = neg_q ? -q_next : q_next;
    assign r_final = neg_r ? -r_next : r_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: default assigned first so no path through the case leaves state_next unassigned (no latch).
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = div_zero ? DONE : RUN;
            RUN:     if (last)      state_next = DONE;
            DONE:                   state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_reg  <= '0;
            r_reg  <= '0;
            d_reg  <= '0;
            cnt    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            dbz_r  <= 1'b0;
            quot_r <= '0;
            rem_r  <= '0;
        end else begin
            busy_r <= (state_next == RUN);
            done_r <= (state_next == DONE);
            if (accept) begin
                if (div_zero) begin
                    quot_r <= '1;
                    rem_r  <= bus.dividend;
                    dbz_r  <= 1'b1;
                end else begin
                    q_reg <= a_mag;
                    d_reg <= b_mag;
                    r_reg <= '0;
                    cnt   <= '0;
                    neg_q <= a_neg ^ b_neg;
                    neg_r <= a_neg;
                end
            end else if (state == RUN) begin
                q_reg <= q_next;
                r_reg <= r_next;
                cnt   <= cnt + CNT_W'(1);
                if (last) begin
                    quot_r <= q_final;
                    rem_r  <= r_final;
                    dbz_r  <= 1'b0;
                end
            end
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.quotient    = quot_r;
    assign bus.remainder   = rem_r;
    assign bus.div_by_zero = dbz_r;
endmodule

// File: tb/tb_divider32_seq.sv
// Self-checking bench for divider32_seq: cycle-level arithmetic model plus directed vectors.
// Signed vectors run only when DIVIDER_SIGNED_EN is defined.
module tb_divider32_seq;
    localparam int W = 32;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    divider32_seq_if #(.WIDTH(W)) bus ();
    divider32_seq #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: plain integer division, signed through 64-bit to avoid overflow.
    function automatic logic [63:0] model_div(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        longint sa, sb;
        logic [31:0] q, r;
        if (sgn) begin
            sa = $signed(a);
            sb = $signed(b);
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {q, r};
    endfunction

    logic model_sgn;
`ifdef DIVIDER_SIGNED_EN
    assign model_sgn = bus.is_signed;
`else
    assign model_sgn = 1'b0;
`endif

    // Cycle model: phase 0 idle, >0 edges still to run, -1 the done cycle.
    int          phase = 0;
    logic        exp_busy = 1'b0, exp_done = 1'b0, exp_dbz = 1'b0;
    logic [31:0] exp_q = '0, exp_r = '0, pend_q = '0, pend_r = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            phase    <= 0;
            exp_busy <= 1'b0;
            exp_done <= 1'b0;
            exp_dbz  <= 1'b0;
            exp_q    <= '0;
            exp_r    <= '0;
        end else begin
            exp_done <= 1'b0;
            if (phase == 0) begin
                if (bus.start) begin
                    if (bus.divisor == '0) begin
                        exp_q    <= '1;
                        exp_r    <= bus.dividend;
                        exp_dbz  <= 1'b1;
                        exp_done <= 1'b1;
                        phase    <= -1;
                    end else begin
                        {pend_q, pend_r} <= model_div(bus.dividend, bus.divisor, model_sgn);
                        exp_busy <= 1'b1;
                        phase    <= W;
                    end
                end
            end else if (phase > 1) begin
                phase <= phase - 1;
            end else if (phase == 1) begin
                exp_busy <= 1'b0;
                exp_done <= 1'b1;
                exp_q    <= pend_q;
                exp_r    <= pend_r;
                exp_dbz  <= 1'b0;
                phase    <= -1;
            end else begin
                phase <= 0;
            end
        end
    end

    always @(negedge clk) begin
        check("cyc busy", bus.busy, exp_busy);
        check("cyc done", bus.done, exp_done);
        check("cyc quotient", bus.quotient, exp_q);
        check("cyc remainder", bus.remainder, exp_r);
        check("cyc div_by_zero", bus.div_by_zero, exp_dbz);
    end

    task automatic wait_done(output int n);
        n = 0;
        for (int i = 1; i <= W + 8; i++) begin
            @(negedge clk);
            if (bus.done) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic start_only(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
`ifdef DIVIDER_SIGNED_EN
        bus.is_signed = sgn;
`endif
        @(negedge clk);
        bus.start    = 1'b0;
        bus.dividend = $urandom;
        bus.divisor  = $urandom;
    endtask

    // Full divide with latency, busy-length and result checks against hand-computed values.
    task automatic run_div(input string name, input logic [31:0] a, input logic [31:0] b, input bit sgn,
                           input int lat, input int busy_len,
                           input logic [31:0] q, input logic [31:0] r, input logic dbz);
        int n;
        int busy_cnt;
        n = 0;
        busy_cnt = 0;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
`ifdef DIVIDER_SIGNED_EN
        bus.is_signed = sgn;
`endif
        for (int i = 1; i <= W + 8; i++) begin
            @(negedge clk);
            if (i == 1) begin
                bus.start    = 1'b0;
                bus.dividend = $urandom;
                bus.divisor  = $urandom;
            end
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                n = i;
                break;
            end
        end
        check({name, " latency"}, n, lat);
        check({name, " busy cycles"}, busy_cnt, busy_len);
        check({name, " quotient"}, bus.quotient, q);
        check({name, " remainder"}, bus.remainder, r);
        check({name, " div_by_zero"}, bus.div_by_zero, dbz);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
`ifdef DIVIDER_SIGNED_EN
        bus.is_signed = 1'b0;
`endif
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        check("reset busy", bus.busy, 1'b0);
        check("reset done", bus.done, 1'b0);
        check("reset quotient", bus.quotient, 32'h0);
        check("reset remainder", bus.remainder, 32'h0);
        check("reset div_by_zero", bus.div_by_zero, 1'b0);
        reset = 1'b0;

        run_div("100/7", 32'd100, 32'd7, 1'b0, W + 1, W, 32'd14, 32'd2, 1'b0);
        run_div("ffffffff/1", 32'hFFFF_FFFF, 32'd1, 1'b0, W + 1, W, 32'hFFFF_FFFF, 32'd0, 1'b0);
        run_div("ffffffff/ffffffff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, W + 1, W, 32'd1, 32'd0, 1'b0);
        run_div("80000001/c0000000", 32'h8000_0001, 32'hC000_0000, 1'b0, W + 1, W, 32'd0, 32'h8000_0001, 1'b0);
        run_div("5/0", 32'd5, 32'd0, 1'b0, 1, 0, 32'hFFFF_FFFF, 32'd5, 1'b1);
        run_div("9/3", 32'd9, 32'd3, 1'b0, W + 1, W, 32'd3, 32'd0, 1'b0);

        // A start pulse in the middle of a divide must be dropped.
        start_only(32'd1000, 32'd3, 1'b0);
        repeat (9) @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 32'd50;
        bus.divisor  = 32'd5;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(n);
        check("ignore latency", n, W - 10);
        check("ignore quotient", bus.quotient, 32'd333);
        check("ignore remainder", bus.remainder, 32'd1);

        // Start held through RUN and DONE is taken only once back in IDLE.
        start_only(32'd1000, 32'd3, 1'b0);
        bus.start    = 1'b1;
        bus.dividend = 32'd50;
        bus.divisor  = 32'd5;
        wait_done(n);
        check("hold first latency", n, W);
        check("hold first quotient", bus.quotient, 32'd333);
        @(negedge clk);
        check("hold idle busy", bus.busy, 1'b0);
        check("hold idle done", bus.done, 1'b0);
        @(negedge clk);
        check("hold accepted busy", bus.busy, 1'b1);
        bus.start = 1'b0;
        wait_done(n);
        check("hold second latency", n, W);
        check("hold second quotient", bus.quotient, 32'd10);
        check("hold second remainder", bus.remainder, 32'd0);

        // Asynchronous reset in the middle of a divide.
        start_only(32'd1000, 32'd3, 1'b0);
        repeat (14) @(negedge clk);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("midrun reset busy", bus.busy, 1'b0);
        check("midrun reset done", bus.done, 1'b0);
        check("midrun reset quotient", bus.quotient, 32'h0);
        check("midrun reset remainder", bus.remainder, 32'h0);
        check("midrun reset div_by_zero", bus.div_by_zero, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        run_div("20/6", 32'd20, 32'd6, 1'b0, W + 1, W, 32'd3, 32'd2, 1'b0);

`ifdef DIVIDER_SIGNED_EN
        run_div("s -7/2", 32'hFFFF_FFF9, 32'd2, 1'b1, W + 1, W, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        run_div("s 7/-2", 32'd7, 32'hFFFF_FFFE, 1'b1, W + 1, W, 32'hFFFF_FFFD, 32'd1, 1'b0);
        run_div("s min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, W + 1, W, 32'h8000_0000, 32'd0, 1'b0);
        run_div("s -5/0", 32'hFFFF_FFFB, 32'd0, 1'b1, 1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1);
`endif

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
